// File: rtl/csr_dfh_responder.sv
// csr_dfh_responder: 64-bit AXI4-Lite CSR responder exposing the OFS feature
// header (DFH, GUID_L, GUID_H), a byte-writable scratchpad and a write counter.
// One write and one read are in flight at a time; all responses are registered.
// Optional feature macro: CSR_RESP_SLVERR_EN (unmapped accesses answer SLVERR).
module csr_dfh_responder #(
   parameter int          ADDR_W         = 16,
   parameter logic [63:0] DFH_VALUE      = 64'h3000000010000020,
   parameter logic [63:0] GUID_L_VALUE   = 64'hBEE40B2B259849A9,
   parameter logic [63:0] GUID_H_VALUE   = 64'hA8E434048329FE10,
   parameter logic [15:0] SCRATCH_OFFSET = 16'h0028
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              awvalid_i,
   output logic              awready_o,
   input  logic [ADDR_W-1:0] awaddr_i,
   input  logic              wvalid_i,
   output logic              wready_o,
   input  logic [63:0]       wdata_i,
   input  logic [7:0]        wstrb_i,
   output logic              bvalid_o,
   input  logic              bready_i,
   output logic [1:0]        bresp_o,
   input  logic              arvalid_i,
   output logic              arready_o,
   input  logic [ADDR_W-1:0] araddr_i,
   output logic              rvalid_o,
   input  logic              rready_i,
   output logic [63:0]       rdata_o,
   output logic [1:0]        rresp_o
);

   localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef CSR_RESP_SLVERR_EN
   localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
   localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

   localparam logic [ADDR_W-1:0] OFF_DFH     = ADDR_W'(16'h0000);
   localparam logic [ADDR_W-1:0] OFF_GUID_L  = ADDR_W'(16'h0008);
   localparam logic [ADDR_W-1:0] OFF_GUID_H  = ADDR_W'(16'h0010);
   localparam logic [ADDR_W-1:0] OFF_SCRATCH = ADDR_W'(SCRATCH_OFFSET);
   localparam logic [ADDR_W-1:0] OFF_WR_CNT  = ADDR_W'(16'h0030);

   typedef enum logic {W_IDLE, W_RESP} wState_e;
   typedef enum logic {R_IDLE, R_DATA} rState_e;

   wState_e           wState_q, wState_d;
   rState_e           rState_q, rState_d;
   logic              awHeld_q, awHeld_d;
   logic              wHeld_q, wHeld_d;
   logic [ADDR_W-1:0] awAddr_q, awAddr_d;
   logic [63:0]       wData_q, wData_d;
   logic [7:0]        wStrb_q, wStrb_d;
   logic [63:0]       scratch_q, scratch_d;
   logic [31:0]       wrCnt_q, wrCnt_d;
   logic [1:0]        bResp_q, bResp_d;
   logic [63:0]       rData_q, rData_d;
   logic [1:0]        rResp_q, rResp_d;
   logic              awReady_q, awReady_d;
   logic              wReady_q, wReady_d;
   logic              arReady_q, arReady_d;
   logic [63:0]       rdLookup;
   logic              rdHit;

   // Offsets are all 8-aligned, so a misaligned address never matches.
   function automatic logic isMapped(input logic [ADDR_W-1:0] addr);
      return (addr == OFF_DFH) || (addr == OFF_GUID_L) || (addr == OFF_GUID_H) ||
             (addr == OFF_SCRATCH) || (addr == OFF_WR_CNT);
   endfunction

   assign rdHit = isMapped(araddr_i);

   // Read mux: unmapped addresses fall through to zero.
   always_comb begin
      rdLookup = '0;
      if (araddr_i == OFF_DFH)          rdLookup = DFH_VALUE;
      else if (araddr_i == OFF_GUID_L)  rdLookup = GUID_L_VALUE;
      else if (araddr_i == OFF_GUID_H)  rdLookup = GUID_H_VALUE;
      else if (araddr_i == OFF_SCRATCH) rdLookup = scratch_q;
      else if (araddr_i == OFF_WR_CNT)  rdLookup = {32'h0, wrCnt_q};
   end

   // Write FSM: capture AW and W independently, commit when both are held.
   always_comb begin
      wState_d  = wState_q;
      awHeld_d  = awHeld_q;
      awAddr_d  = awAddr_q;
      wHeld_d   = wHeld_q;
      wData_d   = wData_q;
      wStrb_d   = wStrb_q;
      scratch_d = scratch_q;
      wrCnt_d   = wrCnt_q;
      bResp_d   = bResp_q;
      case (wState_q)
         W_IDLE: begin
            if (awvalid_i && awReady_q) begin
               awHeld_d = 1'b1;
               awAddr_d = awaddr_i;
            end
            if (wvalid_i && wReady_q) begin
               wHeld_d = 1'b1;
               wData_d = wdata_i;
               wStrb_d = wstrb_i;
            end
            if (awHeld_d && wHeld_d) begin
               if (awAddr_d == OFF_SCRATCH) begin
                  for (int i = 0; i < 8; i++) begin
                     if (wStrb_d[i]) scratch_d[i*8 +: 8] = wData_d[i*8 +: 8];
                  end
               end
               wrCnt_d  = wrCnt_q + 32'd1;
               bResp_d  = isMapped(awAddr_d) ? RESP_OKAY : RESP_UNMAPPED;
               awHeld_d = 1'b0;
               wHeld_d  = 1'b0;
               wState_d = W_RESP;
            end
         end
         W_RESP: begin
            if (bready_i) wState_d = W_IDLE;
         end
         default: wState_d = W_IDLE;
      endcase
   end

   // Read FSM: latch the addressed value on AR handshake, hold until rready.
   always_comb begin
      rState_d = rState_q;
      rData_d  = rData_q;
      rResp_d  = rResp_q;
      case (rState_q)
         R_IDLE: begin
            if (arvalid_i && arReady_q) begin
               rData_d  = rdLookup;
               rResp_d  = rdHit ? RESP_OKAY : RESP_UNMAPPED;
               rState_d = R_DATA;
            end
         end
         R_DATA: begin
            if (rready_i) rState_d = R_IDLE;
         end
         default: rState_d = R_IDLE;
      endcase
   end

   assign awReady_d = (wState_d == W_IDLE) && !awHeld_d;
   assign wReady_d  = (wState_d == W_IDLE) && !wHeld_d;
   assign arReady_d = (rState_d == R_IDLE);

   // State and registered handshake outputs; readies rise one edge after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wState_q  <= W_IDLE;
         rState_q  <= R_IDLE;
         awHeld_q  <= 1'b0;
         wHeld_q   <= 1'b0;
         awAddr_q  <= '0;
         wData_q   <= '0;
         wStrb_q   <= '0;
         scratch_q <= '0;
         wrCnt_q   <= '0;
         bResp_q   <= '0;
         rData_q   <= '0;
         rResp_q   <= '0;
         awReady_q <= 1'b0;
         wReady_q  <= 1'b0;
         arReady_q <= 1'b0;
      end else begin
         wState_q  <= wState_d;
         rState_q  <= rState_d;
         awHeld_q  <= awHeld_d;
         wHeld_q   <= wHeld_d;
         awAddr_q  <= awAddr_d;
         wData_q   <= wData_d;
         wStrb_q   <= wStrb_d;
         scratch_q <= scratch_d;
         wrCnt_q   <= wrCnt_d;
         bResp_q   <= bResp_d;
         rData_q   <= rData_d;
         rResp_q   <= rResp_d;
         awReady_q <= awReady_d;
         wReady_q  <= wReady_d;
         arReady_q <= arReady_d;
      end
   end

   assign awready_o = awReady_q;
   assign wready_o  = wReady_q;
   assign arready_o = arReady_q;
   assign bvalid_o  = (wState_q == W_RESP);
   assign bresp_o   = bResp_q;
   assign rvalid_o  = (rState_q == R_DATA);
   assign rdata_o   = rData_q;
   assign rresp_o   = rResp_q;

endmodule
